// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - D-stage stall control from Tuse/Tnew hazards and MDU busy sequencing
// Optional stall cycle counter port enabled by HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_is_md,
  input  logic [4:0] E_A3,
  input  logic [4:0] M_A3,
  input  logic [1:0] E_Tnew,
  input  logic [1:0] M_Tnew,
  input  logic       E_start,
  input  logic       E_is_div,
  output logic       stall,
  output logic       F_PC_WE,
  output logic       D_REG_WE,
  output logic       E_REG_clr,
  output logic       md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0] cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       md_stall;

  // A start is only honoured from idle; a start during a busy period is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else if (E_start) begin
      cnt <= E_is_div ? DIV_N : MULT_N;
    end
  end

  always_comb begin
    stall_rs = ((D_rs != 5'd0) && (D_rs == E_A3) && (D_Tuse_rs < E_Tnew)) ||
               ((D_rs != 5'd0) && (D_rs == M_A3) && (D_Tuse_rs < M_Tnew));
    stall_rt = ((D_rt != 5'd0) && (D_rt == E_A3) && (D_Tuse_rt < E_Tnew)) ||
               ((D_rt != 5'd0) && (D_rt == M_A3) && (D_Tuse_rt < M_Tnew));
    md_busy   = (cnt != 4'd0);
    md_stall  = D_is_md && (E_start || md_busy);
    stall     = stall_rs || stall_rt || md_stall;
    F_PC_WE   = ~stall;
    D_REG_WE  = ~stall;
    E_REG_clr = stall;
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
